// File: rtl/search_mul_thr.sv
// Sequential threshold search: steps x until x*y crosses THR in the latched
// direction, or until all 2^N probe values have been tried.
module search_mul_thr #(
    parameter int unsigned      N   = 8,
    parameter logic [2*N-1:0]   THR = 16'hABBA
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           soc,
    input  logic           mode,
    input  logic [N-1:0]   y,
    output logic           eoc,
    output logic [N-1:0]   x,
    output logic [2*N-1:0] out,
    output logic           found
);

    typedef enum logic [1:0] {IDLE, ARMED, STEP, TEST} state_t;

    localparam logic [N:0] LAST_CNT = {1'b1, {N{1'b0}}};

    state_t         state_q;
    logic [N-1:0]   x_q;
    logic [2*N-1:0] out_q;
    logic           eoc_q;
    logic           found_q;
    logic           mode_q;
    logic [N:0]     cnt_q;

    logic [2*N-1:0] prod_d;
    logic           hit_d;
    logic           last_d;

    // Operands are widened first so the product keeps all 2N bits.
    always_comb begin
        prod_d = {{N{1'b0}}, x_q} * {{N{1'b0}}, y};
        hit_d  = mode_q ? (prod_d <= THR) : (prod_d >= THR);
        last_d = (cnt_q == LAST_CNT);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            x_q     <= '0;
            out_q   <= '0;
            eoc_q   <= 1'b1;
            found_q <= 1'b0;
            mode_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (soc) begin
                        state_q <= ARMED;
                        eoc_q   <= 1'b0;
                        found_q <= 1'b0;
                    end
                end
                ARMED: begin
                    if (!soc) begin
                        state_q <= STEP;
                        mode_q  <= mode;
                        cnt_q   <= '0;
                    end
                end
                STEP: begin
                    x_q     <= x_q + 1'b1;
                    cnt_q   <= cnt_q + 1'b1;
                    state_q <= TEST;
                end
                TEST: begin
                    out_q <= {x_q, y};
                    // A hit on the final probe still counts as found.
                    if (hit_d) begin
                        found_q <= 1'b1;
                        eoc_q   <= 1'b1;
                        state_q <= IDLE;
                    end else if (last_d) begin
                        found_q <= 1'b0;
                        eoc_q   <= 1'b1;
                        state_q <= IDLE;
                    end else begin
                        state_q <= STEP;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign eoc   = eoc_q;
    assign x     = x_q;
    assign out   = out_q;
    assign found = found_q;

endmodule

// File: doc/search_mul_thr.md
SEARCH_MUL_THR -- requirements
Module: search_mul_thr

Interface
REQ-001 The block SHALL have parameter N, default 8, meaning the width of x and y.
REQ-002 The block SHALL have parameter THR, default 16'hABBA, 2N bits wide, meaning the product threshold.
REQ-003 The block SHALL have port clock  input  1  meaning the single system clock, with all state updated on its rising edge.
REQ-004 The block SHALL have port reset  input  1  meaning the asynchronous, active-high reset.
REQ-005 The block SHALL have port soc  input  1  meaning start-of-conversion request.
REQ-006 The block SHALL have port mode  input  1  meaning the compare mode: 0 hits when x*y >= THR, 1 hits when x*y <= THR.
REQ-007 The block SHALL have port y  input  N  meaning the external response to x, valid one clock after x changes.
REQ-008 The block SHALL have port eoc  output  1  meaning end-of-conversion, high when idle.
REQ-009 The block SHALL have port x  output  N  meaning the registered probe value.
REQ-010 The block SHALL have port out  output  2N  meaning the registered result {x, y} of the last test.
REQ-011 The block SHALL have port found  output  1  meaning the last conversion ended on a hit, not on exhaustion.

Function
REQ-012 The block SHALL implement the four states IDLE, ARMED, STEP and TEST, with all outputs registered.
REQ-013 In IDLE with soc=1, the block SHALL go to ARMED and set eoc<=0 and found<=0; with soc=0 it SHALL stay in IDLE.
REQ-014 In ARMED, the block SHALL stay while soc=1; on soc=0 it SHALL go to STEP, latch mode internally and clear the test counter cnt (N+1 bits).
REQ-015 In STEP, the block SHALL perform x<=x+1 modulo 2^N and cnt<=cnt+1, then go to TEST.
REQ-016 In TEST, the block SHALL perform out<={x,y} and evaluate the full 2N-bit unsigned product x*y against THR using the latched mode.
REQ-017 On a hit in TEST, the block SHALL set found<=1 and eoc<=1 and go to IDLE.
REQ-018 With no hit and cnt==2^N in TEST, the block SHALL set found<=0 and eoc<=1 and go to IDLE (exhaustion).
REQ-019 With no hit and cnt<2^N in TEST, the block SHALL go to STEP.
REQ-020 Each test SHALL take exactly 2 clocks, so a hit on test k SHALL raise eoc 2k clocks after the STEP entry edge.
REQ-021 The block SHALL NOT reset x at conversion start, so each search begins at the previous x+1.
REQ-022 Exhaustion SHALL leave x equal to its value at conversion start, after wrapping.
REQ-023 The block SHALL ignore soc and mode changes in STEP and TEST.
REQ-024 The mode latched at ARMED exit SHALL govern the whole conversion.
REQ-025 The product SHALL be computed without truncation, with the comparison unsigned and 2N bits wide.
REQ-026 When the hit test and the last-test (cnt==2^N) condition coincide, the block SHALL treat it as a hit and set found=1.

Reset
REQ-027 While reset=1, the block SHALL force, asynchronously and independently of clock: state=IDLE, eoc=1, x=0, out=0, found=0, cnt=0.
REQ-028 Reset asserted mid-conversion SHALL abort immediately, with no partial update of out or found on reset release.
REQ-029 After reset is released, the block SHALL resume normal operation at the first rising clock edge.

Verification
REQ-030 A bench SHALL cover: reset; N=8; y=8'hFF constant; mode=0; soc pulsed 1 clock -> tests x=1..173, then eoc=1, found=1, x=8'hAD, out=16'hADFF, 346 clocks after STEP entry.
REQ-031 A bench SHALL cover: reset; y=8'hFF; mode=1; soc pulse -> first test hits, eoc=1 after 2 clocks, x=8'h01, out=16'h01FF, found=1.
REQ-032 A bench SHALL cover: reset; y=8'h00; mode=0; soc pulse -> 256 tests, eoc=1 after 512 clocks, found=0, x=8'h00, out=16'h0000.
REQ-033 A bench SHALL cover: soc held high 5 clocks -> eoc=0 one clock after the first sampled soc, x unchanged while soc=1, stepping begins after soc falls.
REQ-034 A bench SHALL cover: reset asserted mid-TEST between clock edges -> eoc=1, x=0, out=0, found=0 before the next edge; a new soc then searches from x=1.
REQ-035 A bench SHALL cover: back-to-back conversions with y=8'hFF, mode=0 -> second conversion starts at x=8'hAE and hits immediately, giving out=16'hAEFF.
